// File: rtl/lcd_resp_pkg.sv
// Shared types and constants for the 8080-style LCD bus responder.
// Read support in the top level is enabled by defining LCD_RESP_READ_EN.
package lcd_resp_pkg;

    localparam int LCD_DATA_W  = 16;
    localparam int LCD_COORD_W = 9;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam logic [7:0] CMD_RDID  = 8'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARAM  = 2'd1,
        PIXEL  = 2'd2,
        READID = 2'd3
    } lcd_state_e;

    typedef struct packed {
        logic [LCD_DATA_W-1:0]  data;
        logic [LCD_COORD_W-1:0] x;
        logic [LCD_COORD_W-1:0] y;
    } pix_entry_t;

    // Word returned on a read outside READID: last command, FSM state, overflow flag.
    function automatic logic [15:0] status_word(input logic [7:0] cmd,
                                                input lcd_state_e st,
                                                input logic ovf_bit);
        return {cmd, st, ovf_bit, 5'b0};
    endfunction

endpackage

// File: rtl/lcd_resp_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on
// o_head_data whenever o_empty is low; a push on full is accepted only with a pop.
module lcd_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/lcd_bus_responder.sv
// Device end of a bit-banged 16-bit 8080 LCD bus: decodes window/pixel commands into a
// pixel FIFO and, with LCD_RESP_READ_EN defined, answers ID/status reads on lcd_data.
module lcd_bus_responder
    import lcd_resp_pkg::*;
#(
    parameter int                DATA_W     = LCD_DATA_W,
    parameter int                COORD_W    = LCD_COORD_W,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] ID_WORD0   = 16'h0093,
    parameter logic [DATA_W-1:0] ID_WORD1   = 16'h0041
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [DATA_W-1:0]  lcd_data,
    input  logic               lcd_cs_n,
    input  logic               lcd_rs,
    input  logic               lcd_wr_n,
    input  logic               lcd_rd_n,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [DATA_W-1:0]  pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic [1:0]         dbg_state
);

    logic              r_cs_s1, r_cs_s2, r_cs_prev;
    logic              r_rs_s1, r_rs_s2;
    logic              r_wr_s1, r_wr_s2, r_wr_prev;
    logic              r_rd_s1, r_rd_s2, r_rd_prev;
    logic [DATA_W-1:0] r_data_s1, r_data_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_prev <= 1'b1;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_prev <= 1'b1;
            r_rd_s1   <= 1'b1;
            r_rd_s2   <= 1'b1;
            r_rd_prev <= 1'b1;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_cs_s1   <= lcd_cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_prev <= r_cs_s2;
            r_rs_s1   <= lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_wr_s1   <= lcd_wr_n;
            r_wr_s2   <= r_wr_s1;
            r_wr_prev <= r_wr_s2;
            r_rd_s1   <= lcd_rd_n;
            r_rd_s2   <= r_rd_s1;
            r_rd_prev <= r_rd_s2;
            r_data_s1 <= lcd_data;
            r_data_s2 <= r_data_s1;
        end
    end

    // RD must be high on both sides of the WR edge, so strobes released together are ignored.
    logic w_wr_rise;
    logic w_cs_rise;
    assign w_wr_rise = r_wr_s2 & ~r_wr_prev & ~r_cs_s2 & r_rd_s2 & r_rd_prev;
    assign w_cs_rise = r_cs_s2 & ~r_cs_prev;

    logic              r_evt;
    logic              r_evt_rs;
    logic [DATA_W-1:0] r_evt_data;
    logic              r_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt      <= 1'b0;
            r_evt_rs   <= 1'b0;
            r_evt_data <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_evt      <= w_wr_rise;
            r_evt_rs   <= r_rs_s2;
            r_evt_data <= r_data_s2;
            r_abort    <= w_cs_rise;
        end
    end

    logic       w_cmd_wr;
    logic [7:0] w_cmd_byte;
    assign w_cmd_wr   = r_evt & ~r_evt_rs;
    assign w_cmd_byte = r_evt_data[7:0];

    lcd_state_e r_state;
    lcd_state_e w_state_nxt;
    logic [7:0] r_cmd;
    logic [1:0] r_param_idx;
    logic       w_param_take;
    logic       w_param_last;
    logic       w_load_x;
    logic       w_load_y;
    logic       w_pix_push;
    logic       w_cursor_load;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_wr) begin
            case (w_cmd_byte)
                CMD_CASET, CMD_PASET: w_state_nxt = PARAM;
                CMD_RAMWR:            w_state_nxt = PIXEL;
`ifdef LCD_RESP_READ_EN
                CMD_RDID:             w_state_nxt = READID;
`endif
                default:              w_state_nxt = IDLE;
            endcase
        end else if (w_param_last) begin
            w_state_nxt = IDLE;
        end
        if (r_abort) w_state_nxt = IDLE;
    end

    always_comb begin
        w_param_take  = r_evt & r_evt_rs & (r_state == PARAM);
        w_param_last  = w_param_take & (r_param_idx == 2'd3);
        w_load_x      = w_param_last & (r_cmd == CMD_CASET);
        w_load_y      = w_param_last & (r_cmd == CMD_PASET);
        w_pix_push    = r_evt & r_evt_rs & (r_state == PIXEL);
        w_cursor_load = w_cmd_wr & (w_cmd_byte == CMD_RAMWR);
    end

    logic [7:0]         r_p0, r_p1, r_p2;
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye;
    logic [COORD_W-1:0] r_x, r_y;
    logic               w_x_wrap, w_y_wrap;
    logic [COORD_W-1:0] w_x_nxt, w_y_nxt;

    // An inverted window (start > end) pins that axis to its start coordinate.
    always_comb begin
        w_x_wrap = (r_xs > r_xe) || (r_x >= r_xe);
        w_y_wrap = (r_ys > r_ye) || (r_y >= r_ye);
        w_x_nxt  = w_x_wrap ? r_xs : r_x + COORD_W'(1);
        w_y_nxt  = r_y;
        if (w_x_wrap) w_y_nxt = w_y_wrap ? r_ys : r_y + COORD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd       <= 8'h00;
            r_param_idx <= 2'd0;
            r_p0        <= 8'h00;
            r_p1        <= 8'h00;
            r_p2        <= 8'h00;
            r_xs        <= '0;
            r_xe        <= '1;
            r_ys        <= '0;
            r_ye        <= '1;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            if (w_cmd_wr) begin
                r_cmd       <= w_cmd_byte;
                r_param_idx <= 2'd0;
            end
            if (w_param_take) begin
                r_param_idx <= r_param_idx + 2'd1;
                case (r_param_idx)
                    2'd0:    r_p0 <= w_cmd_byte;
                    2'd1:    r_p1 <= w_cmd_byte;
                    2'd2:    r_p2 <= w_cmd_byte;
                    default: ;
                endcase
            end
            if (w_load_x) begin
                r_xs <= COORD_W'({r_p0, r_p1});
                r_xe <= COORD_W'({r_p2, w_cmd_byte});
            end
            if (w_load_y) begin
                r_ys <= COORD_W'({r_p0, r_p1});
                r_ye <= COORD_W'({r_p2, w_cmd_byte});
            end
            if (w_cursor_load) begin
                r_x <= r_xs;
                r_y <= r_ys;
            end else if (w_pix_push) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end
        end
    end

    logic       r_push;
    pix_entry_t r_push_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push       <= 1'b0;
            r_push_entry <= '0;
        end else begin
            r_push <= w_pix_push;
            if (w_pix_push) r_push_entry <= '{data: r_evt_data, x: r_x, y: r_y};
        end
    end

    pix_entry_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_drop;

    lcd_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_entry_t))
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (r_push),
        .i_push_data (r_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign pix_valid = ~w_empty;
    assign pix_data  = w_head.data;
    assign pix_x     = w_head.x;
    assign pix_y     = w_head.y;
    assign w_pop     = pix_valid & pix_ready;
    assign w_drop    = r_push & w_full & ~w_pop;

    logic r_ovf;
    always_ff @(posedge clk) begin
        if (reset)        r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
        else if (ovf_clr) r_ovf <= 1'b0;
    end
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

`ifdef LCD_RESP_READ_EN
    logic              w_rd_rise;
    logic              r_id_started;
    logic              r_oe;
    logic [DATA_W-1:0] r_rd_data;

    assign w_rd_rise = r_rd_s2 & ~r_rd_prev & ~r_cs_s2 & r_wr_s2 & r_wr_prev;

    // The ID index restarts on every command write and moves on after the first read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_started <= 1'b0;
            r_oe         <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (w_cmd_wr)                               r_id_started <= 1'b0;
            else if (w_rd_rise && (r_state == READID))  r_id_started <= 1'b1;
            r_oe      <= ~r_cs_s2 & ~r_rd_s2 & r_wr_s2;
            r_rd_data <= (r_state == READID) ? (r_id_started ? ID_WORD1 : ID_WORD0)
                                             : DATA_W'(status_word(r_cmd, r_state, r_ovf));
        end
    end

    assign lcd_data = r_oe ? r_rd_data : {DATA_W{1'bz}};
`else
    assign lcd_data = {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: host bus tasks, pixel pops and status/ID reads,
// each compared against hand-computed values.
module tb_lcd_bus_responder;
    import lcd_resp_pkg::*;

    localparam logic [15:0] BUS_FLOAT = 16'hFFFF;

    logic       clk = 1'b0;
    logic       reset;
    tri1 [15:0] lcd_data;
    logic [15:0] tb_data;
    logic       tb_drv;
    logic       lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic       pix_valid, pix_ready;
    logic [15:0] pix_data;
    logic [8:0] pix_x, pix_y;
    logic       ovf, ovf_clr;
    logic [1:0] dbg_state;
    logic [15:0] rd_word;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    assign lcd_data = tb_drv ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    lcd_bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .lcd_data  (lcd_data),
        .lcd_cs_n  (lcd_cs_n),
        .lcd_rs    (lcd_rs),
        .lcd_wr_n  (lcd_wr_n),
        .lcd_rd_n  (lcd_rd_n),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host write; clr raises ovf_clr exactly on the edge the pixel reaches the FIFO.
    task automatic host_write(input logic rs_i, input logic [15:0] d, input logic clr);
        @(negedge clk);
        lcd_cs_n = 1'b0;
        lcd_rs   = rs_i;
        tb_data  = d;
        tb_drv   = 1'b1;
        lcd_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ovf_clr = clr;
        @(posedge clk);
        @(negedge clk);
        ovf_clr = 1'b0;
        tb_drv  = 1'b0;
    endtask

    task automatic host_read(output logic [15:0] d);
        @(negedge clk);
        lcd_cs_n = 1'b0;
        lcd_rd_n = 1'b0;
        repeat (5) @(negedge clk);
        d = lcd_data;
        lcd_rd_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_pulse_high();
        @(negedge clk);
        lcd_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        lcd_cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] d,
                             input logic [8:0] x, input logic [8:0] y);
        @(negedge clk);
        check(tag, {pix_valid, pix_data, pix_x, pix_y}, {1'b1, d, x, y});
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached after %0d checks", check_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tb_data = 16'h0000; tb_drv = 1'b0;
        lcd_cs_n = 1'b1; lcd_rs = 1'b0; lcd_wr_n = 1'b1; lcd_rd_n = 1'b1;
        pix_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", pix_valid, 1'b0);
        check("rst_data", pix_data, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_bus", lcd_data, BUS_FLOAT);

        // Latency: pix_valid must appear on the 4th edge after WR_n is first sampled high.
        host_write(1'b0, 16'h002C, 1'b0);
        @(negedge clk);
        tb_data = 16'h1234; tb_drv = 1'b1; lcd_rs = 1'b1; lcd_cs_n = 1'b0; lcd_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 check("lat_edge3", pix_valid, 1'b0);
        @(posedge clk);
        #1 check("lat_edge4", pix_valid, 1'b1);
        repeat (2) @(negedge clk);
        tb_drv = 1'b0;
        pop_check("lat_pix", 16'h1234, 9'd0, 9'd0);

        // Window x 2..3 (high bytes of params are junk), y 5..6, then a wrapping stream.
        host_write(1'b0, 16'h002A, 1'b0);
        host_write(1'b1, 16'hFF00, 1'b0);
        host_write(1'b1, 16'h1102, 1'b0);
        host_write(1'b1, 16'h0000, 1'b0);
        host_write(1'b1, 16'h0003, 1'b0);
        host_write(1'b0, 16'h002B, 1'b0);
        host_write(1'b1, 16'h0000, 1'b0);
        host_write(1'b1, 16'h0005, 1'b0);
        host_write(1'b1, 16'h0000, 1'b0);
        host_write(1'b1, 16'h0006, 1'b0);
        host_write(1'b0, 16'h002C, 1'b0);
        host_write(1'b1, 16'hAAAA, 1'b0);
        host_write(1'b1, 16'hBBBB, 1'b0);
        host_write(1'b1, 16'hCCCC, 1'b0);
        host_write(1'b1, 16'hDDDD, 1'b0);
        host_write(1'b1, 16'hEEEE, 1'b0);
        pop_check("win_a", 16'hAAAA, 9'd2, 9'd5);
        pop_check("win_b", 16'hBBBB, 9'd3, 9'd5);
        pop_check("win_c", 16'hCCCC, 9'd2, 9'd6);
        pop_check("win_d", 16'hDDDD, 9'd3, 9'd6);
        pop_check("win_e", 16'hEEEE, 9'd2, 9'd5);

        // Abort after two CASET params: window stays 2..3.
        host_write(1'b0, 16'h002A, 1'b0);
        host_write(1'b1, 16'h0000, 1'b0);
        host_write(1'b1, 16'h0007, 1'b0);
        cs_pulse_high();
        check("abort_state", dbg_state, IDLE);
`ifdef LCD_RESP_READ_EN
        host_read(rd_word);
        check("abort_status", rd_word, 16'h2A00);
        check("abort_bus_rel", lcd_data, BUS_FLOAT);
`endif
        host_write(1'b0, 16'h002C, 1'b0);
        host_write(1'b1, 16'hC0DE, 1'b0);
        pop_check("abort_win", 16'hC0DE, 9'd2, 9'd5);

        // Read ID sequence.
        host_write(1'b0, 16'h0004, 1'b0);
`ifdef LCD_RESP_READ_EN
        check("rdid_state", dbg_state, READID);
        host_read(rd_word);
        check("rdid_w0", rd_word, 16'h0093);
        check("rdid_z0", lcd_data, BUS_FLOAT);
        host_read(rd_word);
        check("rdid_w1", rd_word, 16'h0041);
        check("rdid_z1", lcd_data, BUS_FLOAT);
        host_read(rd_word);
        check("rdid_w2", rd_word, 16'h0041);
        check("rdid_z2", lcd_data, BUS_FLOAT);
`else
        check("rdid_state", dbg_state, IDLE);
        host_read(rd_word);
        check("no_drive", rd_word, BUS_FLOAT);
`endif

        // WR and RD low together, released together: no push and no bus drive.
        host_write(1'b0, 16'h002C, 1'b0);
        @(negedge clk);
        lcd_rs = 1'b1; lcd_cs_n = 1'b0; lcd_wr_n = 1'b0; lcd_rd_n = 1'b0;
        repeat (5) @(negedge clk);
        check("corner_bus", lcd_data, BUS_FLOAT);
        lcd_wr_n = 1'b1; lcd_rd_n = 1'b1;
        repeat (8) @(negedge clk);
        check("corner_nopush", pix_valid, 1'b0);
        check("corner_state", dbg_state, PIXEL);

        // Overflow: 16 held, 17th dropped, then a clear coinciding with a drop loses.
        for (int i = 0; i < 16; i++) host_write(1'b1, 16'h1000 + 16'(i), 1'b0);
        check("ovf_before", ovf, 1'b0);
        host_write(1'b1, 16'h1010, 1'b0);
        check("ovf_set", ovf, 1'b1);
        check("ovf_head", pix_data, 16'h1000);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 1'b0);
        host_write(1'b1, 16'h1011, 1'b1);
        check("ovf_drop_wins", ovf, 1'b1);
        for (int i = 0; i < 16; i++)
            pop_check($sformatf("ovf_pop%0d", i), 16'h1000 + 16'(i),
                      9'd2 + 9'(i & 1), 9'd5 + 9'((i >> 1) & 1));
        check("ovf_drained", pix_valid, 1'b0);

        // Reset in the middle of a pixel stream.
        host_write(1'b1, 16'h2000, 1'b0);
        host_write(1'b1, 16'h2001, 1'b0);
`ifdef LCD_RESP_READ_EN
        @(negedge clk);
        lcd_rd_n = 1'b0;
        repeat (5) @(negedge clk);
        check("stat_pixel", lcd_data, 16'h2CA0);
        reset = 1'b1;
        @(posedge clk);
        #1 check("rst_bus_rel", lcd_data, BUS_FLOAT);
        @(negedge clk);
        lcd_rd_n = 1'b1;
`else
        @(negedge clk);
        reset = 1'b1;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", pix_valid, 1'b0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_state", dbg_state, IDLE);
        host_write(1'b0, 16'h002C, 1'b0);
        host_write(1'b1, 16'h3333, 1'b0);
        pop_check("mid_rst_cursor", 16'h3333, 9'd0, 9'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
